memory_dp: RTL

Parametrised simple dual-port RAM with one write port, one read port, a configurable registered read latency and a hardware clear sequencer that zeroes every location after reset. It succeeds the fixed 16-entry memory block and is the general storage primitive behind line buffers and lookup tables in the design. `o_rd_valid` and `o_init_done` let upstream logic run without fixed-delay bookkeeping.

---
 rtl/memory_dp.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/memory_dp.sv
`default_nettype none
// ============================================================================
// Module   : memory_dp
// Purpose  : Parametrised simple dual-port RAM (one write port, one read
//            port) with a registered read latency of 1 or 2 cycles and a
//            clear sequencer that zeroes every word after reset.
// Options  : `MEMORY_DP_BYPASS_EN - when defined, a same-address read/write
//            collision returns the new write data (write-first); otherwise
//            the old contents are returned (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module memory_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_init_done,
  output logic              o_addr_err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range test.
  localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic              addr_err_q;
  logic              addr_err_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range = ({1'b0, i_wr_addr} < c_DEPTH);
  assign rd_in_range = ({1'b0, i_rd_addr} < c_DEPTH);

  // State register and clear pointer; reset restarts the clear from word 0.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state, memory write port steering and access acceptance.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = i_wr_addr;
    mem_wdata  = i_wr_data;
    rd_acc     = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // User strobes are ignored; the write port belongs to the clearer.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == c_LAST_ADDR) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end
      end
      ST_READY: begin
        // Out-of-range writes are dropped, out-of-range reads still return.
        mem_we     = i_wr & wr_in_range;
        rd_acc     = i_rd;
        addr_err_d = (i_wr & ~wr_in_range) | (i_rd & ~rd_in_range);
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Memory array write; no reset, the clear sequence initialises it.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read word selection: zero for out-of-range, optional write forwarding.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[i_rd_addr];
    end
`ifdef MEMORY_DP_BYPASS_EN
    if (i_wr && wr_in_range && rd_in_range && (i_wr_addr == i_rd_addr)) begin
      rd_word = i_wr_data;
    end
`endif
  end

  // Address error flag, one cycle after the offending access.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_data_q;
      logic              s1_valid_q;

      // Two-stage read pipeline: array capture, then output register.
      always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          s1_valid_q <= rd_acc;
          if (rd_acc) begin
            s1_data_q <= rd_word;
          end
          rd_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            rd_data_q <= s1_data_q;
          end
        end
      end
    end else begin : g_lat1
      // Single output register; data holds while no read completes.
      always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= rd_word;
          end
        end
      end
    end
  endgenerate

  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_init_done = (state_q == ST_READY);
  assign o_addr_err  = addr_err_q;

endmodule
`default_nettype wire
